// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
//  Module   : datapath
//  Purpose  : 32-bit single-bus CPU datapath. Sixteen GP registers plus PC,
//             IR, Y, Z (2*WIDTH), HI, LO, MAR and MDR share one bus driven by
//             a select-encoded mux. A combinational ALU takes Y as operand A
//             and the bus as operand B; its result is captured into Z.
//             There is no control unit: every enable comes from outside.
//  Ports    : clock, clear          - clock and synchronous active-high reset
//             incPC                 - Z captures {0, bus+1} instead of ALU
//             GP_addr               - GP register-file write address
//             Mdatain, MDR_read     - memory read data / MDR source select
//             e_PC .. e_GP          - per-register load enables
//             ALU_op                - ALU operation code
//             BusDataSelect         - bus source select
//             BusMuxOut             - current bus value
//  Revision : 1.0  initial release
// ============================================================================
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             incPC,
    input  logic [3:0]       GP_addr,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             MDR_read,
    input  logic             e_PC,
    input  logic             e_IR,
    input  logic             e_Y,
    input  logic             e_Z,
    input  logic             e_HI,
    input  logic             e_LO,
    input  logic             e_MDR,
    input  logic             e_MAR,
    input  logic             e_GP,
    input  logic [3:0]       ALU_op,
    input  logic [4:0]       BusDataSelect,
    output logic [WIDTH-1:0] BusMuxOut
);

    localparam int c_SHW = $clog2(WIDTH);

    // Bus source codes (codes 00000-01111 select R0-R15 directly).
    localparam logic [4:0] c_SEL_HI  = 5'b10000;
    localparam logic [4:0] c_SEL_LO  = 5'b10001;
    localparam logic [4:0] c_SEL_ZHI = 5'b10010;
    localparam logic [4:0] c_SEL_ZLO = 5'b10011;
    localparam logic [4:0] c_SEL_PC  = 5'b10100;
    localparam logic [4:0] c_SEL_MDR = 5'b10101;

    // ALU operation codes.
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_SHR  = 4'b0100;
    localparam logic [3:0] c_OP_SHL  = 4'b0101;
    localparam logic [3:0] c_OP_ROR  = 4'b0110;
    localparam logic [3:0] c_OP_ROL  = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;
    localparam logic [3:0] c_OP_DIV  = 4'b1001;
    localparam logic [3:0] c_OP_NEG  = 4'b1010;
    localparam logic [3:0] c_OP_NOT  = 4'b1011;
    localparam logic [3:0] c_OP_SHRA = 4'b1100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_gp [16];
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_z;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;

    // ------------------------------------------------------------------
    // Bus multiplexer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bus;

    always_comb begin
        w_bus = '0;
        if (!BusDataSelect[4]) begin
            w_bus = r_gp[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect)
                c_SEL_HI:  w_bus = r_hi;
                c_SEL_LO:  w_bus = r_lo;
                c_SEL_ZHI: w_bus = r_z[2*WIDTH-1:WIDTH];
                c_SEL_ZLO: w_bus = r_z[WIDTH-1:0];
                c_SEL_PC:  w_bus = r_pc;
                c_SEL_MDR: w_bus = r_mdr;
                default:   w_bus = '0;
            endcase
        end
    end

    assign BusMuxOut = w_bus;

    // ------------------------------------------------------------------
    // ALU: A = Y, B = bus
    // ------------------------------------------------------------------
    logic [c_SHW-1:0]          w_shamt;
    logic [2*WIDTH-1:0]        w_ror_ext;
    logic [2*WIDTH-1:0]        w_rol_ext;
    logic [WIDTH-1:0]          w_shra;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_quo;
    logic signed [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0]        w_alu;
    logic [2*WIDTH-1:0]        w_z_next;

    assign w_shamt = w_bus[c_SHW-1:0];

    // Rotates are taken from a doubled copy of A so a zero amount needs no
    // special case.
    assign w_ror_ext = {r_y, r_y} >> w_shamt;
    assign w_rol_ext = {r_y, r_y} << w_shamt;
    assign w_shra    = $signed(r_y) >>> w_shamt;

    // Both operands are sign-extended to full product width first so the
    // multiply is exact in 2*WIDTH bits.
    assign w_prod = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) *
                    $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});

    // Divide by zero is forced to zero rather than left to the simulator.
    always_comb begin
        w_quo = '0;
        w_rem = '0;
        if (w_bus != '0) begin
            w_quo = $signed(r_y) / $signed(w_bus);
            w_rem = $signed(r_y) % $signed(w_bus);
        end
    end

    always_comb begin
        w_alu = '0;
        case (ALU_op)
            c_OP_ADD:  w_alu[WIDTH-1:0] = r_y + w_bus;
            c_OP_SUB:  w_alu[WIDTH-1:0] = r_y - w_bus;
            c_OP_AND:  w_alu[WIDTH-1:0] = r_y & w_bus;
            c_OP_OR:   w_alu[WIDTH-1:0] = r_y | w_bus;
            c_OP_SHR:  w_alu[WIDTH-1:0] = r_y >> w_shamt;
            c_OP_SHL:  w_alu[WIDTH-1:0] = r_y << w_shamt;
            c_OP_ROR:  w_alu[WIDTH-1:0] = w_ror_ext[WIDTH-1:0];
            c_OP_ROL:  w_alu[WIDTH-1:0] = w_rol_ext[2*WIDTH-1:WIDTH];
            c_OP_MUL:  w_alu            = w_prod;
            c_OP_DIV:  w_alu            = {w_rem, w_quo};
            c_OP_NEG:  w_alu[WIDTH-1:0] = -w_bus;
            c_OP_NOT:  w_alu[WIDTH-1:0] = ~w_bus;
            c_OP_SHRA: w_alu[WIDTH-1:0] = w_shra;
            default:   w_alu[WIDTH-1:0] = w_bus;
        endcase
    end

    assign w_z_next = incPC ? {{WIDTH{1'b0}}, w_bus + 1'b1} : w_alu;

    // ------------------------------------------------------------------
    // Registers. All sources read the pre-edge bus, so a register selected
    // while being written drives its old value for that cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                r_gp[i] <= '0;
            end
            r_pc  <= '0;
            r_ir  <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (e_GP)  r_gp[GP_addr] <= w_bus;
            if (e_PC)  r_pc  <= w_bus;
            if (e_IR)  r_ir  <= w_bus;
            if (e_Y)   r_y   <= w_bus;
            if (e_HI)  r_hi  <= w_bus;
            if (e_LO)  r_lo  <= w_bus;
            if (e_MAR) r_mar <= w_bus;
            if (e_MDR) r_mdr <= MDR_read ? Mdatain : w_bus;
            if (e_Z)   r_z   <= w_z_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath
//  Purpose  : Self-checking bench for datapath: directed hand-sequences for
//             reset, enable isolation, MDR/GP, SHRA, PC increment and
//             read-during-write, plus a table of ALU vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_datapath;

    logic        clock;
    logic        clear;
    logic        incPC;
    logic [3:0]  GP_addr;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic [31:0] BusMuxOut;

    int errors = 0;
    int checks = 0;

    // Destination codes for the put task.
    localparam int c_D_HI  = 16;
    localparam int c_D_LO  = 17;
    localparam int c_D_PC  = 18;
    localparam int c_D_Y   = 19;
    localparam int c_D_MDR = 20;
    localparam int c_D_MAR = 21;

    datapath #(.WIDTH(32)) dut (
        .clock         (clock),
        .clear         (clear),
        .incPC         (incPC),
        .GP_addr       (GP_addr),
        .Mdatain       (Mdatain),
        .MDR_read      (MDR_read),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .e_MDR         (e_MDR),
        .e_MAR         (e_MAR),
        .e_GP          (e_GP),
        .ALU_op        (ALU_op),
        .BusDataSelect (BusDataSelect),
        .BusMuxOut     (BusMuxOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
        string       name;
    } vec_t;

    vec_t vecs [21];

    task automatic idle();
        e_PC = 0; e_IR = 0; e_Y = 0; e_Z = 0; e_HI = 0; e_LO = 0;
        e_MDR = 0; e_MAR = 0; e_GP = 0; incPC = 0; clear = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bus(input logic [4:0] sel, input logic [31:0] exp,
                           input string name);
        BusDataSelect = sel;
        #1;
        check(name, {32'b0, BusMuxOut}, {32'b0, exp});
    endtask

    task automatic read_z(output logic [63:0] z);
        BusDataSelect = 5'b10010;
        #1;
        z[63:32] = BusMuxOut;
        BusDataSelect = 5'b10011;
        #1;
        z[31:0] = BusMuxOut;
    endtask

    // Value enters through Mdatain -> MDR, then MDR -> bus -> destination.
    task automatic put(input logic [31:0] v, input int dest);
        Mdatain = v; MDR_read = 1; e_MDR = 1;
        tick();
        if (dest != c_D_MDR) begin
            BusDataSelect = 5'b10101;
            case (dest)
                c_D_HI:  e_HI  = 1;
                c_D_LO:  e_LO  = 1;
                c_D_PC:  e_PC  = 1;
                c_D_Y:   e_Y   = 1;
                c_D_MAR: e_MAR = 1;
                default: begin GP_addr = dest[3:0]; e_GP = 1; end
            endcase
            tick();
        end
    endtask

    logic [31:0] exp_src [22];
    logic [63:0] z;

    initial begin
        vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 64'h0, "add_wrap"};
        vecs[1]  = '{4'b0000, 32'h00000005, 32'h00000003, 64'h8, "add"};
        vecs[2]  = '{4'b0001, 32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE, "sub"};
        vecs[3]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, "and"};
        vecs[4]  = '{4'b0011, 32'hF0F0F0F0, 32'h0F0F0000, 64'h00000000_FFFFF0F0, "or"};
        vecs[5]  = '{4'b0100, 32'h80000000, 32'h00000024, 64'h00000000_08000000, "shr_hibits"};
        vecs[6]  = '{4'b0101, 32'h00000001, 32'h0000001F, 64'h00000000_80000000, "shl31"};
        vecs[7]  = '{4'b0101, 32'h12345678, 32'h00000000, 64'h00000000_12345678, "shl0"};
        vecs[8]  = '{4'b0110, 32'h12345678, 32'h00000004, 64'h00000000_81234567, "ror4"};
        vecs[9]  = '{4'b0111, 32'h12345678, 32'h00000008, 64'h00000000_34567812, "rol8"};
        vecs[10] = '{4'b0110, 32'h12345678, 32'h00000020, 64'h00000000_12345678, "ror0"};
        vecs[11] = '{4'b1000, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, "mul"};
        vecs[12] = '{4'b1001, 32'h00000007, 32'h00000002, 64'h00000001_00000003, "div"};
        vecs[13] = '{4'b1001, 32'h00000007, 32'h00000000, 64'h0, "div0"};
        vecs[14] = '{4'b1001, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div_neg"};
        vecs[15] = '{4'b1010, 32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF, "neg"};
        vecs[16] = '{4'b1011, 32'h00000000, 32'h0F0F0F0F, 64'h00000000_F0F0F0F0, "not"};
        vecs[17] = '{4'b1100, 32'h80000000, 32'h0000001F, 64'h00000000_FFFFFFFF, "shra31"};
        vecs[18] = '{4'b1100, 32'h40000000, 32'h00000001, 64'h00000000_20000000, "shra_pos"};
        vecs[19] = '{4'b1101, 32'h00000000, 32'hDEADBEEF, 64'h00000000_DEADBEEF, "pass_d"};
        vecs[20] = '{4'b1111, 32'h00000000, 32'h12345678, 64'h00000000_12345678, "pass_f"};

        idle();
        GP_addr = 0; Mdatain = 0; MDR_read = 0; ALU_op = 0; BusDataSelect = 0;

        // ---- Reset after arbitrary loads ----
        clear = 1;
        tick();
        put(32'hA5A5A5A5, 5);
        put(32'h5A5A5A5A, c_D_HI);
        put(32'h00001000, c_D_PC);
        put(32'h0000BEEF, c_D_MAR);
        BusDataSelect = 5'b10101; incPC = 1; e_Z = 1;
        tick();
        clear = 1; e_GP = 1; e_Z = 1; e_PC = 1; GP_addr = 5;
        tick();
        for (int s = 0; s < 22; s++) chk_bus(s[4:0], 32'h0, $sformatf("reset_src%0d", s));
        chk_bus(5'b11111, 32'h0, "bus_unused_code");
        check("reset_mar", {32'b0, dut.r_mar}, 64'h0);
        chk_bus(5'b10011, 32'h0, "reset_zlo");

        // ---- Enable isolation ----
        put(32'h11111111, 1);
        put(32'h22222222, c_D_HI);
        for (int s = 0; s < 22; s++) exp_src[s] = 32'h0;
        exp_src[1]  = 32'h11111111;
        exp_src[16] = 32'h22222222;
        exp_src[21] = 32'h22222222;   // MDR still holds the last put value
        for (int k = 0; k < 6; k++) begin
            BusDataSelect = k[0] ? 5'b00001 : 5'b10000;
            ALU_op = k[3:0];
            Mdatain = 32'hC0DE0000 + k;
            MDR_read = k[0];
            GP_addr = k[3:0];
            tick();
        end
        for (int s = 0; s < 22; s++) chk_bus(s[4:0], exp_src[s], $sformatf("iso_src%0d", s));

        // ---- MDR loads bus when MDR_read=0 ----
        BusDataSelect = 5'b00001; MDR_read = 0; Mdatain = 32'hAAAAAAAA; e_MDR = 1;
        tick();
        chk_bus(5'b10101, 32'h11111111, "mdr_from_bus");

        // ---- MDR/GP path ----
        Mdatain = 32'hFFFFFF88; MDR_read = 1; e_MDR = 1;
        tick();
        BusDataSelect = 5'b10101; GP_addr = 3; e_GP = 1;
        tick();
        chk_bus(5'b00011, 32'hFFFFFF88, "r3_load");

        // ---- SHRA sequence ----
        put(32'h00000002, 7);
        BusDataSelect = 5'b00011; e_Y = 1;
        tick();
        BusDataSelect = 5'b00111; ALU_op = 4'b1100; e_Z = 1;
        tick();
        BusDataSelect = 5'b10011; GP_addr = 4; e_GP = 1;
        tick();
        chk_bus(5'b00100, 32'hFFFFFFE2, "shra_r4");
        chk_bus(5'b10010, 32'h0, "shra_zhi");

        // ---- PC increment ----
        put(32'h00000077, c_D_MAR);
        BusDataSelect = 5'b10100; e_MAR = 1; incPC = 1; e_Z = 1;
        tick();
        check("pc_mar", {32'b0, dut.r_mar}, 64'h0);
        chk_bus(5'b10011, 32'h1, "pc_zlo");
        chk_bus(5'b10010, 32'h0, "pc_zhi");
        BusDataSelect = 5'b10011; e_PC = 1;
        tick();
        chk_bus(5'b10100, 32'h1, "pc_loaded");

        // ---- Read-during-write on Z ----
        BusDataSelect = 5'b10011; incPC = 1; e_Z = 1;
        #1;
        check("rdw_old", {32'b0, BusMuxOut}, 64'h1);
        tick();
        chk_bus(5'b10011, 32'h2, "rdw_new");

        // ---- ALU table ----
        for (int i = 0; i < 21; i++) begin
            put(vecs[i].a, c_D_Y);
            put(vecs[i].b, c_D_MDR);
            BusDataSelect = 5'b10101; ALU_op = vecs[i].op; e_Z = 1;
            tick();
            read_z(z);
            check(vecs[i].name, z, vecs[i].z);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath (Mini SRC style) for phase-1 bring-up: sixteen general-purpose registers, PC, IR, Y, Z (64-bit), HI, LO, MAR and MDR, all on one shared bus driven by a select-encoded multiplexer.
- A combinational ALU takes Y as operand A and the bus as operand B. Its result is captured into Z.
- All control comes from an external sequencer or testbench. There is no internal control unit.

Parameters:
- WIDTH, 32, datapath word width. Z is 2*WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- incPC  in  1  Z captures bus+1 instead of the ALU result.
- GP_addr  in  4  write address for the GP register file.
- Mdatain  in  32  memory read data into MDR.
- MDR_read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  in  1 each  register load enables.
- ALU_op  in  4  ALU operation.
- BusDataSelect  in  5  bus source select.
- BusMuxOut  out  32  current bus value, for observation.

Behaviour:
- Reset: on a rising edge with clear=1, every register (R0-R15, PC, IR, Y, Z, HI, LO, MAR, MDR) goes to 0. Reset overrides all enables.
- Bus mux (combinational):
  - 00000-01111: R0-R15. R0 is an ordinary register.
  - 10000: HI. 10001: LO.
  - 10010: Z[63:32]. 10011: Z[31:0].
  - 10100: PC. 10101: MDR.
  - Any other code: 0.
- Register loads on the rising edge when the enable is 1; otherwise the register holds.
  - PC, IR, Y, HI, LO, MAR load from the bus.
  - e_GP writes R[GP_addr] from the bus.
  - MDR loads Mdatain if MDR_read=1, else the bus.
  - Z loads the ALU result, or {32'b0, bus+1} if incPC=1.
- Read-during-write: a register selected onto the bus while being written drives its old value. The new value is visible the cycle after the edge.
- ALU, combinational, A=Y, B=bus, 64-bit result. Upper 32 bits are 0 unless stated.
  - 0000 ADD; 0001 SUB (A-B); 0010 AND; 0011 OR.
  - 0100 SHR (logical, A>>B[4:0]); 0101 SHL.
  - 0110 ROR; 0111 ROL (both by B[4:0]).
  - 1000 MUL: signed 32x32 -> 64.
  - 1001 DIV: signed; Z[31:0]=quotient, Z[63:32]=remainder. Divide by zero gives Z=0.
  - 1010 NEG (-B); 1011 NOT (~B).
  - 1100 SHRA: arithmetic right shift of A by B[4:0], sign-filled.
  - 1101-1111: pass B.
  - Add and subtract wrap modulo 2^32. No flags.
- Shifts by 0 pass A through unchanged. Shift amounts use only B[4:0]; higher bits of B are ignored.
- Single-cycle control protocol: the sequencer asserts enables after a rising edge and holds them one full period. Capture occurs on the following edge.

Test Plan:
- Reset: hold clear=1 for one edge after arbitrary loads -> every register reads 0 via the bus; BusMuxOut=0 with select 10011.
- MDR/GP path: Mdatain=FFFFFF88, MDR_read=1, e_MDR=1 for one edge; then select 10101, GP_addr=3, e_GP=1 -> R3=FFFFFF88 (check via select 00011).
- SHRA: R3=FFFFFF88, R7=00000002. Sequence: select 00011 with e_Y; then select 00111, ALU_op=1100, e_Z; then select 10011, GP_addr=4, e_GP -> R4=FFFFFFE2, Z[63:32]=0.
- PC increment: PC=0. Select 10100 with e_MAR, incPC, e_Z -> MAR=0, Z[31:0]=1. Then select 10011 with e_PC -> PC=1.
- MUL/DIV: Y=FFFFFFFE (-2), bus=3.
  - MUL -> Z=FFFFFFFF_FFFFFFFA.
  - DIV with Y=7, bus=2 -> Z[31:0]=3, Z[63:32]=1.
  - DIV with bus=0 -> Z=0.
- Enable isolation: with all enables 0 across several edges while the bus and ALU toggle -> no register changes. MDR with MDR_read=0 loads the bus value instead of Mdatain.
